// File: rtl/mem_responder_if.sv
// mem_responder_if: TinyMIPS byte-bus request/response signals between CPU and memory.
interface mem_responder_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
);
    logic              memread;
    logic              memwrite;
    logic [ADDR_W-1:0] adr;
    logic [WIDTH-1:0]  writedata;
    logic [WIDTH-1:0]  memdata;
    logic              mem_ready;
    modport master (output memread, memwrite, adr, writedata, input memdata, mem_ready);
    modport slave  (input memread, memwrite, adr, writedata, output memdata, mem_ready);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: byte-array memory with programmable read latency and an output/halt port.
module mem_responder #(
    parameter int                WIDTH  = 8,
    parameter int                ADDR_W = 8,
    parameter int                RD_LAT = 1,
    parameter logic [ADDR_W-1:0] IO_ADR = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    output logic [WIDTH-1:0]     io_data,
    output logic                 io_valid,
    output logic                 halt,
    output logic [15:0]          wr_count
);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT > 1 ? RD_LAT - 2 : 0);
    logic [WIDTH-1:0]  mem [2**ADDR_W];
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_adr_q, rd_adr_d;
    logic [WIDTH-1:0]  memdata_q, memdata_d, io_data_q, io_data_d;
    logic              mem_ready_q, mem_ready_d, io_valid_q, io_valid_d, halt_q, halt_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              idle, io_wr, arr_wr, rd, done;
    logic [ADDR_W-1:0] rd_sel;
    logic [WIDTH-1:0]  rd_byte;
    always_comb begin
        idle        = state_q == IDLE;
        io_wr       = idle && bus.memwrite && bus.adr == IO_ADR;
        arr_wr      = idle && bus.memwrite && bus.adr != IO_ADR && !halt_q;
        rd          = idle && bus.memread && !bus.memwrite;
        done        = !idle && cnt_q == 3'd0;
        rd_sel      = idle ? bus.adr : rd_adr_q;
        rd_byte     = rd_sel == IO_ADR ? io_data_q : mem[rd_sel];
        state_d     = (rd && RD_LAT > 1) ? RD_WAIT : done ? IDLE : state_q;
        cnt_d       = rd ? CNT_LOAD : (!idle && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
        rd_adr_d    = rd ? bus.adr : rd_adr_q;
        memdata_d   = ((rd && RD_LAT == 1) || done) ? rd_byte : memdata_q;
        mem_ready_d = state_d == IDLE;
        io_data_d   = io_wr ? bus.writedata : io_data_q;
        io_valid_d  = io_wr;
        halt_d      = halt_q || io_wr;
        wr_count_d  = ((io_wr || arr_wr) && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_adr_q    <= '0;
            memdata_q   <= '0;
            mem_ready_q <= 1'b1;
            io_data_q   <= '0;
            io_valid_q  <= 1'b0;
            halt_q      <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_adr_q    <= rd_adr_d;
            memdata_q   <= memdata_d;
            mem_ready_q <= mem_ready_d;
            io_data_q   <= io_data_d;
            io_valid_q  <= io_valid_d;
            halt_q      <= halt_d;
            wr_count_q  <= wr_count_d;
        end
    end
    // Array contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (reset && arr_wr) mem[bus.adr] <= bus.writedata;
    end
    assign bus.memdata   = memdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign io_data       = io_data_q;
    assign io_valid      = io_valid_q;
    assign halt          = halt_q;
    assign wr_count      = wr_count_q;
endmodule
